rx_bit_timer: RTL

RX_BIT_TIMER -- requirements
Module: rx_bit_timer

---
 rtl/rx_bit_timer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/rx_bit_timer.sv
// Receive bit timer: after start-bit detect, paces mid-bit sample strobes for data, parity and stop bits
// of one asynchronous serial frame, then flags end of packet or an illegal configuration.
module rx_bit_timer #(
    parameter int CNT_WIDTH = 14,
    parameter int BIT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable_timer,
    input  logic [CNT_WIDTH-1:0] bit_period,
    input  logic [BIT_WIDTH-1:0] data_bits,
    input  logic                 parity_en,
    input  logic                 stop_bits_2,
    output logic                 shift_enable,
    output logic [BIT_WIDTH:0]   bit_index,
    output logic                 is_parity,
    output logic                 is_stop,
    output logic                 packet_done,
    output logic                 busy,
    output logic                 cfg_error
);

    localparam int NW = BIT_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t               state_q, state_d;

    logic [CNT_WIDTH-1:0] period_q;
    logic [BIT_WIDTH-1:0] dataBits_q;
    logic                 parityEn_q;
    logic                 stop2_q;
    logic [NW-1:0]        numBits_q;

    logic [CNT_WIDTH-1:0] clkCnt_q, clkCnt_d;
    logic [NW-1:0]        bitCnt_q, bitCnt_d;
    logic                 packetDone_q, packetDone_d;
    logic                 cfgError_q, cfgError_d;

    logic                 startReq;
    logic                 cfgLegal;
    logic [NW-1:0]        numBitsIn;
    logic [CNT_WIDTH-1:0] halfPeriod;
    logic                 bitWrap;
    logic                 strobe;
    logic                 lastStrobe;

    assign startReq  = (state_q == IDLE) && enable_timer;
    assign cfgLegal  = (bit_period >= CNT_WIDTH'(2))
                     && (data_bits >= BIT_WIDTH'(5))
                     && (data_bits <= BIT_WIDTH'(9));
    assign numBitsIn = NW'(data_bits) + NW'(parity_en)
                     + (stop_bits_2 ? NW'(2) : NW'(1));

    // Strobe timing depends only on latched configuration and counters, never on live inputs.
    assign halfPeriod = period_q >> 1;
    assign bitWrap    = (clkCnt_q == period_q);
    assign strobe     = (state_q == RUN)
                     && (clkCnt_q == halfPeriod)
                     && (bitCnt_q != NW'(0))
                     && (bitCnt_q <= numBits_q);
    assign lastStrobe = strobe && (bitCnt_q == numBits_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (enable_timer) begin
                    state_d = cfgLegal ? RUN : ERR;
                end
            end
            RUN: begin
                if (!enable_timer) begin
                    state_d = IDLE;
                end else if (lastStrobe) begin
                    state_d = DONE;
                end
            end
            DONE, ERR: begin
                if (!enable_timer) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Configuration is captured only on the start cycle so mid-packet changes cannot disturb timing.
    always_ff @(posedge clk) begin
        if (rst) begin
            period_q   <= '0;
            dataBits_q <= '0;
            parityEn_q <= 1'b0;
            stop2_q    <= 1'b0;
            numBits_q  <= '0;
        end else if (startReq) begin
            period_q   <= bit_period;
            dataBits_q <= data_bits;
            parityEn_q <= parity_en;
            stop2_q    <= stop_bits_2;
            numBits_q  <= numBitsIn;
        end
    end

    always_comb begin
        clkCnt_d     = '0;
        bitCnt_d     = '0;
        packetDone_d = 1'b0;
        cfgError_d   = cfgError_q;
        if (startReq) begin
            cfgError_d = !cfgLegal;
            if (cfgLegal) begin
                clkCnt_d = CNT_WIDTH'(1);
            end
        end else if ((state_q == RUN) && enable_timer) begin
            if (lastStrobe) begin
                packetDone_d = 1'b1;
            end else if (bitWrap) begin
                clkCnt_d = CNT_WIDTH'(1);
                bitCnt_d = bitCnt_q + NW'(1);
            end else begin
                clkCnt_d = clkCnt_q + CNT_WIDTH'(1);
                bitCnt_d = bitCnt_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clkCnt_q     <= '0;
            bitCnt_q     <= '0;
            packetDone_q <= 1'b0;
            cfgError_q   <= 1'b0;
        end else begin
            clkCnt_q     <= clkCnt_d;
            bitCnt_q     <= bitCnt_d;
            packetDone_q <= packetDone_d;
            cfgError_q   <= cfgError_d;
        end
    end

    // Parity is the bit right after the data; everything past data and parity is a stop bit.
    always_comb begin
        shift_enable = strobe;
        bit_index    = strobe ? bitCnt_q : '0;
        is_parity    = strobe && parityEn_q
                    && (bitCnt_q == NW'(dataBits_q) + NW'(1));
        is_stop      = strobe
                    && (bitCnt_q > NW'(dataBits_q) + NW'(parityEn_q));
        packet_done  = packetDone_q;
        busy         = (state_q == RUN);
        cfg_error    = cfgError_q;
    end

    logic unusedStop2;
    assign unusedStop2 = stop2_q;

endmodule
